// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared types for the pipeline hazard interface: the bundles exchanged
// with the hazard unit, the in-flight stage record, and small helpers.
package definitions;

    localparam int REG_BITS = 5;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [REG_BITS-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_BITS-1:0] reg_idx_t;

    // Register indices presented to the hazard unit; 0 means "no hazard".
    typedef struct packed {
        reg_idx_t Drs;
        reg_idx_t Drt;
        reg_idx_t Xrd;
        reg_idx_t Xrt;
        reg_idx_t Mrd;
    } Hazard_input;

    // Decisions returned by the hazard unit.
    typedef struct packed {
        logic stallIF;
        logic stallD;
    } Hazard_output;

    // Record of the instruction occupying the EX stage.
    typedef struct packed {
        logic     valid;
        reg_idx_t dst;
        reg_idx_t rt;
        logic     load;
    } stage_rec_t;

    // An empty slot must always read as register 0.
    function automatic reg_idx_t slot_reg(input logic valid, input reg_idx_t idx);
        return valid ? idx : REG_ZERO;
    endfunction

endpackage

// File: rtl/pipe_hazard_tracker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over
// increment, and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] r_q;

    // Count events, holding at the maximum value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != CNT_MAX)) begin
            r_q <= r_q + W'(1'b1);
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_hazard_tracker.sv
// Bookkeeping side of the hazard interface: tracks EX/MEM/WB occupancy,
// presents register indices to the hazard unit, turns its stall decisions
// into PC / IF-ID enables and EX bubbles, and keeps debug statistics.
import definitions::*;

module pipe_hazard_tracker #(
    parameter int REG_W     = REG_BITS,
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_load,
    input  logic             flush,
    input  Hazard_output     h_o,
    output Hazard_input      h_i,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic             ex_load,
    output logic [REG_W-1:0] wb_dst,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_timeout
);

    localparam int                RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0]  RUN_LIM = RUN_W'(MAX_STALL - 1);

    stage_rec_t       r_x;
    logic             r_m_valid;
    reg_idx_t         r_m_dst;
    logic             r_w_valid;
    reg_idx_t         r_w_dst;
    logic             r_stall_timeout;

    logic             w_bubble;
    logic             w_stall_ev;
    logic [RUN_W-1:0] w_run_cnt;

    // A flush outranks a stall, so a stall is only counted without a flush.
    assign w_bubble   = flush | h_o.stallD | ~id_valid;
    assign w_stall_ev = h_o.stallD & ~flush;

    // Advance the in-flight records; MEM and WB always drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x       <= '0;
            r_m_valid <= 1'b0;
            r_m_dst   <= REG_ZERO;
            r_w_valid <= 1'b0;
            r_w_dst   <= REG_ZERO;
        end else begin
            r_w_valid <= r_m_valid;
            r_w_dst   <= r_m_dst;
            r_m_valid <= r_x.valid;
            r_m_dst   <= r_x.dst;
            if (w_bubble) begin
                r_x <= '0;
            end else begin
                r_x <= '{valid: 1'b1, dst: id_dst, rt: id_rt, load: id_load};
            end
        end
    end

    // Latch the watchdog once a stall run reaches the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_timeout <= 1'b0;
        end else if (w_stall_ev && (w_run_cnt >= RUN_LIM)) begin
            r_stall_timeout <= 1'b1;
        end else begin
            r_stall_timeout <= r_stall_timeout;
        end
    end

    // Indices for the hazard unit; empty slots read as register 0.
    always_comb begin
        h_i     = '0;
        h_i.Drs = slot_reg(id_valid, id_rs);
        h_i.Drt = slot_reg(id_valid, id_rt);
        h_i.Xrd = slot_reg(r_x.valid, r_x.dst);
        h_i.Xrt = slot_reg(r_x.valid, r_x.rt);
        h_i.Mrd = slot_reg(r_m_valid, r_m_dst);
    end

    // A flush reloads IF/ID with the redirected fetch even when stalled.
    always_comb begin
        pc_en   = DISABLE;
        ifid_en = DISABLE;
        if (!reset) begin
            pc_en   = (flush | ~h_o.stallIF) ? ENABLE : DISABLE;
            ifid_en = (flush | ~h_o.stallD)  ? ENABLE : DISABLE;
        end else begin
            pc_en   = DISABLE;
            ifid_en = DISABLE;
        end
    end

    assign ex_valid      = r_x.valid;
    assign mem_valid     = r_m_valid;
    assign wb_valid      = r_w_valid;
    assign ex_load       = r_x.load;
    assign wb_dst        = slot_reg(r_w_valid, r_w_dst);
    assign stall_timeout = r_stall_timeout;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_ev),
        .clr   (1'b0),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .clr   (1'b0),
        .q     (flush_cnt)
    );

    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_ev),
        .clr   (~w_stall_ev),
        .q     (w_run_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Bench for pipe_hazard_tracker: directed scenarios plus randomized traffic
// against a queue-based reference model; a second instance with 4-bit
// counters exercises saturation.
import definitions::*;

module tb_pipe_hazard_tracker;

    logic         clk = 1'b0;
    logic         reset;
    logic         id_valid;
    logic [4:0]   id_rs, id_rt, id_dst;
    logic         id_load;
    logic         flush;
    Hazard_output h_o;

    Hazard_input  h_i;
    logic         pc_en, ifid_en, ex_valid, mem_valid, wb_valid, ex_load, stall_timeout;
    logic [4:0]   wb_dst;
    logic [31:0]  stall_cnt, flush_cnt;

    Hazard_input  s_h_i;
    logic         s_pc_en, s_ifid_en, s_ex_valid, s_mem_valid, s_wb_valid, s_ex_load, s_stall_timeout;
    logic [4:0]   s_wb_dst;
    logic [3:0]   s_stall_cnt, s_flush_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit       v;
        bit [4:0] dst;
        bit [4:0] rt;
        bit       ld;
    } ent_t;

    // Reference model: q[0] is the EX occupant, q[1] MEM, q[2] WB.
    ent_t   q[$];
    longint m_stall, m_flush;
    int     m_run;
    bit     m_to;

    always #5 clk = ~clk;

    pipe_hazard_tracker u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_dst(id_dst), .id_load(id_load), .flush(flush), .h_o(h_o), .h_i(h_i),
        .pc_en(pc_en), .ifid_en(ifid_en), .ex_valid(ex_valid), .mem_valid(mem_valid),
        .wb_valid(wb_valid), .ex_load(ex_load), .wb_dst(wb_dst), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .stall_timeout(stall_timeout)
    );

    pipe_hazard_tracker #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_dst(id_dst), .id_load(id_load), .flush(flush), .h_o(h_o), .h_i(s_h_i),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ex_valid(s_ex_valid), .mem_valid(s_mem_valid),
        .wb_valid(s_wb_valid), .ex_load(s_ex_load), .wb_dst(s_wb_dst), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt), .stall_timeout(s_stall_timeout)
    );

    function automatic ent_t bubble();
        ent_t e;
        e = '{v: 1'b0, dst: 5'd0, rt: 5'd0, ld: 1'b0};
        return e;
    endfunction

    task automatic set_idle();
        reset    = 1'b0;
        id_valid = 1'b0;
        id_rs    = 5'd0;
        id_rt    = 5'd0;
        id_dst   = 5'd0;
        id_load  = 1'b0;
        flush    = 1'b0;
        h_o      = '0;
    endtask

    // One clock edge: advance the model from the current inputs.
    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (reset) begin
            q.delete();
            repeat (3) q.push_back(bubble());
            m_stall = 0;
            m_flush = 0;
            m_run   = 0;
            m_to    = 1'b0;
        end else begin
            e = bubble();
            if (!(flush || h_o.stallD || !id_valid))
                e = '{v: 1'b1, dst: id_dst, rt: id_rt, ld: id_load};
            q.push_front(e);
            void'(q.pop_back());
            if (flush) m_flush++;
            if (h_o.stallD && !flush) begin
                m_stall++;
                m_run++;
                if (m_run >= 16) m_to = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; id_valid = 1'b1; id_dst = 5'd5; id_rs = 5'd9; id_rt = 5'd10;
        repeat (3) tick();
        #1;
        checks++;
        if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin
            failures++; $display("FAIL reset_valids got=%b exp=000", {ex_valid, mem_valid, wb_valid});
        end
        checks++;
        if (h_i !== {5'd9, 5'd10, 5'd0, 5'd0, 5'd0}) begin
            failures++; $display("FAIL reset_h_i got=%h exp=%h", h_i, {5'd9, 5'd10, 15'd0});
        end
        checks++;
        if ({pc_en, ifid_en} !== 2'b00) begin
            failures++; $display("FAIL reset_enables got=%b exp=00", {pc_en, ifid_en});
        end
        checks++;
        if ({stall_cnt, flush_cnt, stall_timeout, wb_dst, ex_load} !== 71'd0) begin
            failures++; $display("FAIL reset_state cnt=%0d/%0d to=%b wb=%0d ld=%b exp=all0",
                                 stall_cnt, flush_cnt, stall_timeout, wb_dst, ex_load);
        end
        set_idle();
    endtask

    task automatic test_flow();
        set_idle();
        id_valid = 1'b1; id_dst = 5'd3; id_rt = 5'd1;
        tick();
        id_dst = 5'd7; id_rt = 5'd2;
        #1;
        checks++;
        if (h_i.Xrd !== 5'd3) begin failures++; $display("FAIL flow_xrd0 got=%0d exp=3", h_i.Xrd); end
        tick();
        set_idle();
        #1;
        checks++;
        if ({h_i.Xrd, h_i.Mrd} !== {5'd7, 5'd3}) begin
            failures++; $display("FAIL flow_xrd1_mrd0 got=%0d,%0d exp=7,3", h_i.Xrd, h_i.Mrd);
        end
        tick();
        #1;
        checks++;
        if ({h_i.Xrd, h_i.Mrd, wb_dst} !== {5'd0, 5'd7, 5'd3}) begin
            failures++; $display("FAIL flow_wb0 got=%0d,%0d,%0d exp=0,7,3", h_i.Xrd, h_i.Mrd, wb_dst);
        end
        tick();
        #1;
        checks++;
        if (wb_dst !== 5'd7) begin failures++; $display("FAIL flow_wb1 got=%0d exp=7", wb_dst); end
    endtask

    task automatic test_stall();
        set_idle();
        id_valid = 1'b1; id_dst = 5'd4;
        tick();
        h_o.stallD = 1'b1; h_o.stallIF = 1'b1; id_dst = 5'd9;
        #1;
        checks++;
        if ({pc_en, ifid_en, h_i.Xrd} !== {2'b00, 5'd4}) begin
            failures++; $display("FAIL stall_enables got=%b%b xrd=%0d exp=00 xrd=4", pc_en, ifid_en, h_i.Xrd);
        end
        tick();
        #1;
        checks++;
        if ({ex_valid, h_i.Mrd, pc_en} !== {1'b0, 5'd4, 1'b0}) begin
            failures++; $display("FAIL stall_bubble1 got=ev%b mrd=%0d pc=%b exp=ev0 mrd=4 pc=0", ex_valid, h_i.Mrd, pc_en);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if ({ex_valid, mem_valid, wb_dst, stall_cnt} !== {2'b00, 5'd4, 32'd2}) begin
            failures++; $display("FAIL stall_drain got=ev%b mv%b wb=%0d cnt=%0d exp=ev0 mv0 wb=4 cnt=2",
                                 ex_valid, mem_valid, wb_dst, stall_cnt);
        end
    endtask

    task automatic test_flush_priority();
        id_valid = 1'b1; id_dst = 5'd6; flush = 1'b1; h_o.stallD = 1'b1; h_o.stallIF = 1'b1;
        #1;
        checks++;
        if ({pc_en, ifid_en} !== 2'b11) begin
            failures++; $display("FAIL flush_enables got=%b%b exp=11", pc_en, ifid_en);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if ({ex_valid, flush_cnt, stall_cnt} !== {1'b0, 32'd1, 32'd2}) begin
            failures++; $display("FAIL flush_counts got=ev%b f=%0d s=%0d exp=ev0 f=1 s=2", ex_valid, flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_watchdog();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        h_o.stallD = 1'b1;
        repeat (15) tick();
        #1;
        checks++;
        if (stall_timeout !== 1'b0) begin failures++; $display("FAIL wd_15 got=%b exp=0", stall_timeout); end
        h_o.stallD = 1'b0;
        tick();
        h_o.stallD = 1'b1;
        repeat (15) tick();
        #1;
        checks++;
        if (stall_timeout !== 1'b0) begin failures++; $display("FAIL wd_gap got=%b exp=0", stall_timeout); end
        tick();
        #1;
        checks++;
        if (stall_timeout !== 1'b1) begin failures++; $display("FAIL wd_16 got=%b exp=1", stall_timeout); end
        set_idle();
        repeat (5) tick();
        #1;
        checks++;
        if ({stall_timeout, stall_cnt} !== {1'b1, 32'd31}) begin
            failures++; $display("FAIL wd_sticky got=%b cnt=%0d exp=1 cnt=31", stall_timeout, stall_cnt);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (stall_timeout !== 1'b0) begin failures++; $display("FAIL wd_reset got=%b exp=0", stall_timeout); end
    endtask

    task automatic test_saturation();
        set_idle();
        flush = 1'b1;
        repeat (20) tick();
        #1;
        checks++;
        if ({s_flush_cnt, flush_cnt} !== {4'd15, 32'd20}) begin
            failures++; $display("FAIL sat_flush got=%0d/%0d exp=15/20", s_flush_cnt, flush_cnt);
        end
        set_idle();
    endtask

    task automatic test_random();
        ent_t       e_x, e_m, e_w;
        logic [36:0] exp_vec;
        for (int n = 0; n < 800; n++) begin
            reset      = ($urandom_range(0, 49) == 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs      = 5'($urandom);
            id_rt      = 5'($urandom);
            id_dst     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            id_load    = 1'($urandom);
            flush      = ($urandom_range(0, 9) == 0);
            h_o.stallD = (n % 200 > 150) ? 1'b1 : ($urandom_range(0, 3) == 0);
            h_o.stallIF = h_o.stallD ? 1'b1 : ($urandom_range(0, 7) == 0);
            #1;
            e_x = q[0];
            e_m = q[1];
            e_w = q[2];
            exp_vec = {!reset && (flush || !h_o.stallIF), !reset && (flush || !h_o.stallD),
                       e_x.v, e_m.v, e_w.v, e_x.ld, (e_w.v ? e_w.dst : 5'd0),
                       (id_valid ? id_rs : 5'd0), (id_valid ? id_rt : 5'd0),
                       (e_x.v ? e_x.dst : 5'd0), (e_x.v ? e_x.rt : 5'd0),
                       (e_m.v ? e_m.dst : 5'd0), m_to};
            checks++;
            if ({pc_en, ifid_en, ex_valid, mem_valid, wb_valid, ex_load, wb_dst, h_i, stall_timeout} !== exp_vec) begin
                failures++;
                $display("FAIL rnd_outputs cyc=%0d got=%h exp=%h", n,
                         {pc_en, ifid_en, ex_valid, mem_valid, wb_valid, ex_load, wb_dst, h_i, stall_timeout}, exp_vec);
            end
            checks++;
            if ({s_pc_en, s_ifid_en, s_ex_valid, s_mem_valid, s_wb_valid, s_ex_load, s_wb_dst, s_h_i, s_stall_timeout} !== exp_vec) begin
                failures++;
                $display("FAIL rnd_outputs_small cyc=%0d got=%h exp=%h", n,
                         {s_pc_en, s_ifid_en, s_ex_valid, s_mem_valid, s_wb_valid, s_ex_load, s_wb_dst, s_h_i, s_stall_timeout}, exp_vec);
            end
            checks++;
            if ({stall_cnt, flush_cnt} !== {32'(m_stall), 32'(m_flush)}) begin
                failures++; $display("FAIL rnd_counters cyc=%0d got=%0d/%0d exp=%0d/%0d", n, stall_cnt, flush_cnt, m_stall, m_flush);
            end
            checks++;
            if ({s_stall_cnt, s_flush_cnt} !== {4'((m_stall > 15) ? 15 : m_stall), 4'((m_flush > 15) ? 15 : m_flush)}) begin
                failures++; $display("FAIL rnd_sat_counters cyc=%0d got=%0d/%0d exp=%0d/%0d", n, s_stall_cnt, s_flush_cnt,
                                     (m_stall > 15) ? 15 : m_stall, (m_flush > 15) ? 15 : m_flush);
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        repeat (3) q.push_back(bubble());
        m_stall = 0;
        m_flush = 0;
        m_run   = 0;
        m_to    = 1'b0;
        set_idle();
        @(negedge clk);
        test_reset();
        test_flow();
        test_stall();
        test_flush_priority();
        test_watchdog();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
